seq_arith_inverse_unit_29: RTL and testbench
============================================

// Module: seq_arith_inverse_unit_29
// PURPOSE
//  Companion to the synchronous arithmetic unit. Performs the inverse operation set:
//  left shift (inverse of right shift), A > ~B (complement of A <= ~B),
//  A * ~B (inverse of A / ~B) and U2(A) => ZM(A) (inverse of ZM => U2).
//  It sits next to the forward unit on the same operand/opcode bus, adding a start/busy/valid handshake.
//  The multiply is iterative (one shift-add step per clock); all other ops complete in one execute cycle.
// PARAMETERS
//  M  32  operand/result width in bits (M >= 4)
// PORTS
//  clk       in   1   clock; all logic on rising edge
//  i_reset   in   1   synchronous, active-high reset
//  i_start   in   1   request; sampled only in IDLE
//  iarg_A    in   M   operand A, captured when start is accepted
//  iarg_B    in   M   operand B, captured when start is accepted
//  iop       in   4   opcode, captured when start is accepted
//  o_result  out  M   result; held until the next accepted start
//  o_status  out  4   [0] ERR  [1] OVF  [2] ZERO (result==0)  [3] ODD (odd count of 1s in result)
//  o_busy    out  1   high in CALC and DONE
//  o_valid   out  1   one-cycle pulse in DONE; o_result/o_status are valid from this cycle
// BEHAVIOUR
//  Reset (edge with i_reset=1)
//   - state=IDLE; o_result=0, o_status=0, o_busy=0, o_valid=0.
//   - Any operation in flight is abandoned; reset has priority over i_start.
//  FSM: IDLE -> CALC -> DONE -> IDLE
//   - IDLE, i_start=1 at edge k: capture A, B, iop; go to CALC.
//   - CALC, non-multiply op: result and status register at edge k+1; go to DONE.
//   - CALC, multiply: uses a 2M-bit accumulator and a step counter 0..M-1, one step per edge.
//     It finishes at edge k+M and then goes to DONE.
//   - DONE: o_valid=1 for exactly one cycle; next edge returns to IDLE.
//   - i_start is ignored while o_busy=1 (no queueing). A new start is possible in the first IDLE cycle.
//  Operations (unsigned unless stated)
//   - 4'b0000: result = A << B.
//       If B >= M: result=0 and OVF = (A != 0).
//       Otherwise OVF = 1 if any 1 bit is shifted out.
//   - 4'b0001: result = (A > ~B) ? 1 : 0; OVF=0.
//   - 4'b0010: full product P = A * ~B (2M bits); result = P[M-1:0]; OVF = |P[2M-1:M].
//   - 4'b0011: U2 -> ZM.
//       If A[M-1]=0: result = A.
//       Else: result = {1'b1, (-A)[M-2:0]}.
//       A = 1 followed by M-1 zeros is not representable: result=0, ERR=1, OVF=1.
//   - Any other opcode: result=0, ERR=1, latency as for a non-multiply op.
//  Status
//   - ZERO and ODD are computed from the final registered result.
//   - ERR and OVF are cleared on every accepted start.
//  Latency: o_valid is high in the cycle after edge k+1 (non-multiply) or after edge k+M (multiply).
// TESTING
//  1) A=15, B=3, op 0000, start -> o_valid after 2nd edge; result=120, status=4'b0000.
//  2) A=10, B=5, op 0001 (~B=0xFFFFFFFA) -> result=0, status=4'b0100 (ZERO).
//  3) A=20, B=0xFFFFFFFB, op 0010 (~B=4) -> result=80; o_busy high 33 cycles; o_valid pulses once.
//  4) op 0011:
//       A=0xFFFFFF7F -> result=0x80000081.
//       A=0x80000000 -> result=0, status=4'b0111 (ERR, OVF, ZERO).
//  5) op 0111, A=B=1 -> result=0, ERR=1, ZERO=1.
//     A second start issued while busy -> ignored; only one o_valid pulse.
//  6) Reset asserted during multiply step 10 -> next edge: o_busy=0, o_valid=0, o_result=0.
//     A fresh op 0000 afterwards completes normally.

Source files
------------

// File: rtl/seq_arith_inverse_unit_29.sv
// Sequential inverse arithmetic unit: left shift, A > ~B, iterative A * ~B, and U2 -> ZM,
// behind a start/busy/valid handshake.
module seq_arith_inverse_unit_29 #(
    parameter int unsigned M = 32
) (
    input  logic         clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [M-1:0] iarg_A,
    input  logic [M-1:0] iarg_B,
    input  logic [3:0]   iop,
    output logic [M-1:0] o_result,
    output logic [3:0]   o_status,
    output logic         o_busy,
    output logic         o_valid
);
    localparam int unsigned    CW      = $clog2(M);
    localparam logic [CW-1:0]  CntLast = CW'(M - 1);
    localparam logic [M-1:0]   MVal    = M'(M);
    localparam logic [M-1:0]   MinNeg  = {1'b1, {(M-1){1'b0}}};
    localparam logic [3:0]     OpShl   = 4'b0000;
    localparam logic [3:0]     OpGt    = 4'b0001;
    localparam logic [3:0]     OpMul   = 4'b0010;
    localparam logic [3:0]     OpZm    = 4'b0011;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e         state_q;
    logic [M-1:0]   a_q;
    logic [M-1:0]   b_q;
    logic [3:0]     op_q;
    logic [2*M-1:0] acc_q;
    logic [CW-1:0]  cnt_q;

    logic [2*M-1:0] shl_wide;
    logic [M-1:0]   neg_a;
    logic [M-1:0]   addend;
    logic [M:0]     mul_sum;
    logic [2*M-1:0] acc_next;
    logic [M-1:0]   fin_res;
    logic           fin_err;
    logic           fin_ovf;

    always_comb begin
        shl_wide = {{M{1'b0}}, a_q} << b_q[CW-1:0];
        neg_a    = ~a_q + 1'b1;
        // Accumulator: high half gathers partial sums, low half shifts the multiplier out.
        addend   = acc_q[0] ? a_q : '0;
        mul_sum  = {1'b0, acc_q[2*M-1:M]} + {1'b0, addend};
        acc_next = {mul_sum, acc_q[M-1:1]};

        fin_res = '0;
        fin_err = 1'b0;
        fin_ovf = 1'b0;
        case (op_q)
            OpShl: begin
                if (b_q >= MVal) begin
                    fin_ovf = |a_q;
                end else begin
                    fin_res = shl_wide[M-1:0];
                    fin_ovf = |shl_wide[2*M-1:M];
                end
            end
            OpGt: fin_res = {{(M-1){1'b0}}, (a_q > ~b_q)};
            OpMul: begin
                fin_res = acc_next[M-1:0];
                fin_ovf = |acc_next[2*M-1:M];
            end
            OpZm: begin
                if (!a_q[M-1]) begin
                    fin_res = a_q;
                end else if (a_q == MinNeg) begin
                    fin_err = 1'b1;
                    fin_ovf = 1'b1;
                end else begin
                    fin_res = {1'b1, neg_a[M-2:0]};
                end
            end
            default: fin_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            o_result <= '0;
            o_status <= '0;
            o_busy   <= 1'b0;
            o_valid  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        a_q           <= iarg_A;
                        b_q           <= iarg_B;
                        op_q          <= iop;
                        acc_q         <= {{M{1'b0}}, ~iarg_B};
                        cnt_q         <= '0;
                        o_status[1:0] <= 2'b00;
                        o_busy        <= 1'b1;
                        state_q       <= StCalc;
                    end
                end
                StCalc: begin
                    // The last multiply step is folded into the result write.
                    if (op_q == OpMul && cnt_q != CntLast) begin
                        acc_q <= acc_next;
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        o_result <= fin_res;
                        o_status <= {^fin_res, ~|fin_res, fin_ovf, fin_err};
                        o_valid  <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_arith_inverse_unit_29.sv
// Bench for seq_arith_inverse_unit_29: arithmetic model with latency bookkeeping, checked
// every cycle, plus directed vectors with literal expectations.
module tb_seq_arith_inverse_unit_29;
    localparam int unsigned M = 32;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [31:0] iarg_A;
    logic [31:0] iarg_B;
    logic [3:0]  iop;
    logic [31:0] o_result;
    logic [3:0]  o_status;
    logic        o_busy;
    logic        o_valid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_arith_inverse_unit_29 #(.M(M)) dut (
        .clk      (clk),
        .i_reset  (i_reset),
        .i_start  (i_start),
        .iarg_A   (iarg_A),
        .iarg_B   (iarg_B),
        .iop      (iop),
        .o_result (o_result),
        .o_status (o_status),
        .o_busy   (o_busy),
        .o_valid  (o_valid)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns {result, ODD, ZERO, OVF, ERR}.
    function automatic logic [35:0] model_op(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
        logic [63:0] p;
        logic [31:0] r;
        logic [31:0] nb;
        logic        err;
        logic        ovf;
        r   = 0;
        err = 0;
        ovf = 0;
        nb  = ~b;
        case (op)
            4'd0: begin
                if (b >= 32) begin
                    ovf = (a != 0);
                end else begin
                    p   = 64'(a) << b;
                    r   = p[31:0];
                    ovf = (p[63:32] != 0);
                end
            end
            4'd1: r = (a > nb) ? 32'd1 : 32'd0;
            4'd2: begin
                p   = 64'(a) * 64'(nb);
                r   = p[31:0];
                ovf = (p[63:32] != 0);
            end
            4'd3: begin
                if (a[31] == 1'b0) r = a;
                else if (a == 32'h8000_0000) begin
                    err = 1;
                    ovf = 1;
                end else r = 32'h8000_0000 | ((32'd0 - a) & 32'h7FFF_FFFF);
            end
            default: err = 1;
        endcase
        return {r, ($countones(r) % 2 == 1), (r == 0), ovf, err};
    endfunction

    // rem = busy cycles still to come; the last one carries the valid pulse and new result.
    int          rem = 0;
    logic [31:0] m_result = '0;
    logic [3:0]  m_status = '0;
    logic [35:0] pend = '0;

    always @(posedge clk) begin
        if (i_reset) begin
            rem      = 0;
            m_result = '0;
            m_status = '0;
        end else if (rem > 0) begin
            rem--;
            if (rem == 1) begin
                m_result = pend[35:4];
                m_status = pend[3:0];
            end
        end else if (i_start) begin
            pend          = model_op(iarg_A, iarg_B, iop);
            m_status[1:0] = 2'b00;
            rem           = (iop == 4'b0010) ? M + 1 : 2;
        end
    end

    bit chk_en = 0;
    int valid_pulses = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc busy", o_busy, rem > 0);
            check("cyc valid", o_valid, rem == 1);
            check("cyc result", o_result, m_result);
            check("cyc status", o_status, m_status);
            if (o_valid) valid_pulses++;
        end
    end

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic [31:0] exp_r,
                          input logic [3:0] exp_s, output int busy_n);
        bit seen;
        iarg_A  = a;
        iarg_B  = b;
        iop     = op;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        seen    = 0;
        busy_n  = 0;
        for (int i = 0; i < 60; i++) begin
            if (o_busy) busy_n++;
            if (o_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check({name, " valid seen"}, seen, 1);
        check({name, " result"}, o_result, exp_r);
        check({name, " status"}, o_status, exp_s);
        @(negedge clk);
    endtask

    initial begin
        int bn;
        int pulses0;
        i_reset = 1'b1;
        i_start = 1'b0;
        iarg_A  = '0;
        iarg_B  = '0;
        iop     = '0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        check("rst result", o_result, 0);
        check("rst status", o_status, 0);
        check("rst busy", o_busy, 0);
        check("rst valid", o_valid, 0);
        i_reset = 1'b0;
        @(negedge clk);

        run_op("shl 15<<3", 32'd15, 32'd3, 4'b0000, 32'd120, 4'b0000, bn);
        check("shl busy cycles", bn, 2);
        run_op("shl ovf", 32'h8000_0001, 32'd1, 4'b0000, 32'd2, 4'b1010, bn);
        run_op("shl b=31", 32'd1, 32'd31, 4'b0000, 32'h8000_0000, 4'b1000, bn);
        run_op("shl b=32", 32'd3, 32'd32, 4'b0000, 32'd0, 4'b0110, bn);
        run_op("shl a=0 b=40", 32'd0, 32'd40, 4'b0000, 32'd0, 4'b0100, bn);
        run_op("gt false", 32'd10, 32'd5, 4'b0001, 32'd0, 4'b0100, bn);
        run_op("gt true", 32'hFFFF_FFFF, 32'd1, 4'b0001, 32'd1, 4'b1000, bn);
        run_op("mul 20*4", 32'd20, 32'hFFFF_FFFB, 4'b0010, 32'd80, 4'b0000, bn);
        check("mul busy cycles", bn, 33);
        run_op("mul ovf", 32'h0001_0000, 32'hFFFE_FFFF, 4'b0010, 32'd0, 4'b0110, bn);
        run_op("zm neg", 32'hFFFF_FF7F, 32'd0, 4'b0011, 32'h8000_0081, 4'b1000, bn);
        run_op("zm minneg", 32'h8000_0000, 32'd0, 4'b0011, 32'd0, 4'b0111, bn);
        run_op("zm pos", 32'd5, 32'd0, 4'b0011, 32'd5, 4'b0000, bn);

        // Illegal opcode with a second start held through CALC and DONE.
        pulses0 = valid_pulses;
        iarg_A  = 32'd1;
        iarg_B  = 32'd1;
        iop     = 4'b0111;
        i_start = 1'b1;
        @(negedge clk);
        iarg_A  = 32'd15;
        iarg_B  = 32'd3;
        iop     = 4'b0000;
        @(negedge clk);
        check("badop valid", o_valid, 1);
        check("badop result", o_result, 0);
        check("badop status", o_status, 4'b0101);
        @(negedge clk);
        i_start = 1'b0;
        repeat (4) @(negedge clk);
        check("busy start ignored pulses", valid_pulses - pulses0, 1);
        check("busy start ignored idle", o_busy, 0);

        // Reset in the middle of a multiply.
        iarg_A  = 32'd20;
        iarg_B  = 32'hFFFF_FFFB;
        iop     = 4'b0010;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (10) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        check("midrst busy", o_busy, 0);
        check("midrst valid", o_valid, 0);
        check("midrst result", o_result, 0);
        run_op("after rst shl", 32'd15, 32'd3, 4'b0000, 32'd120, 4'b0000, bn);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
